// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and constants for the multi-cycle sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam int DEF_TIMEOUT_W = 8;
    localparam int DEF_CNT_W     = 32;

    localparam logic PC_SEL_SEQ = 1'b0;
    localparam logic PC_SEL_BR  = 1'b1;

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - memory wait-cycle counter with limit detect
module seq_wait_timer #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_limit
);

    // o_limit flags the cycle whose missing ack would make the wait count
    // reach 2^TIMEOUT_W-1, so the FSM can fault on that edge unless acked.
    localparam logic [TIMEOUT_W-1:0] LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] r_cnt;

    // Count wait cycles; clear has priority so a fresh wait always starts at zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
        end
    end

    assign o_limit = (r_cnt == LAST);

endmodule

// File: rtl/multicycle_seq.sv
// rtl/multicycle_seq.sv - multi-cycle instruction sequencer with memory handshakes and fault detect
module multicycle_seq
    import seq_pkg::*;
#(
    parameter int TIMEOUT_W = DEF_TIMEOUT_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_start,
    input  logic             io_halt,
    input  logic             io_dec_mem_read,
    input  logic             io_dec_mem_write,
    input  logic             io_dec_reg_write,
    input  logic             io_dec_branch,
    input  logic             io_alu_zero,
    output logic             io_imem_req,
    input  logic             io_imem_ack,
    output logic             io_dmem_req,
    output logic             io_dmem_we,
    input  logic             io_dmem_ack,
    output logic             io_ir_write,
    output logic             io_pc_write,
    output logic             io_pc_sel,
    output logic             io_rf_write,
    output logic             io_busy,
    output logic             io_fault,
    output logic [CNT_W-1:0] io_retired
);

    state_t           r_state;
    logic             r_is_store;
    logic [CNT_W-1:0] r_retired;

    logic   w_in_wait;
    logic   w_ack;
    logic   w_limit;
    logic   w_illegal;
    logic   w_retire;
    state_t w_after_retire;

    assign w_in_wait      = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_ack          = ((r_state == S_FETCH) && io_imem_ack) ||
                            ((r_state == S_MEM)   && io_dmem_ack);
    assign w_illegal      = io_dec_mem_read && io_dec_mem_write;
    assign w_after_retire = io_halt ? S_IDLE : S_FETCH;

    // The timer restarts whenever a wait state completes or is not active,
    // so every FETCH/MEM entry begins from a zero count.
    seq_wait_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (!w_in_wait || w_ack),
        .i_en    (w_in_wait && !w_ack),
        .o_limit (w_limit)
    );

    // Outputs decode from the state plus acks; hints only reach outputs in EXEC
    always_comb begin
        io_imem_req = 1'b0;
        io_ir_write = 1'b0;
        io_dmem_req = 1'b0;
        io_dmem_we  = 1'b0;
        io_rf_write = 1'b0;
        io_pc_sel   = PC_SEL_SEQ;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                io_imem_req = 1'b1;
                io_ir_write = io_imem_ack;
            end
            S_EXEC: begin
                if (!w_illegal) begin
                    if (io_dec_branch) begin
                        w_retire  = 1'b1;
                        io_pc_sel = io_alu_zero ? PC_SEL_BR : PC_SEL_SEQ;
                    end else if (!(io_dec_mem_read || io_dec_mem_write) &&
                                 !io_dec_reg_write) begin
                        w_retire = 1'b1;
                    end
                end
            end
            S_MEM: begin
                io_dmem_req = 1'b1;
                io_dmem_we  = r_is_store;
                w_retire    = io_dmem_ack && r_is_store;
            end
            S_WB: begin
                io_rf_write = 1'b1;
                w_retire    = 1'b1;
            end
            default: ;
        endcase
    end

    assign io_pc_write = w_retire;
    assign io_busy     = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign io_fault    = (r_state == S_FAULT);
    assign io_retired  = r_retired;

    // Instruction-step FSM; FAULT is absorbing until reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_start) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (io_imem_ack)  r_state <= S_DECODE;
                    else if (w_limit) r_state <= S_FAULT;
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_illegal) begin
                        r_state <= S_FAULT;
                    end else if (io_dec_branch) begin
                        r_state <= w_after_retire;
                    end else if (io_dec_mem_read || io_dec_mem_write) begin
                        r_state    <= S_MEM;
                        r_is_store <= io_dec_mem_write;
                    end else if (io_dec_reg_write) begin
                        r_state <= S_WB;
                    end else begin
                        r_state <= w_after_retire;
                    end
                end
                S_MEM: begin
                    if (io_dmem_ack)  r_state <= r_is_store ? w_after_retire : S_WB;
                    else if (w_limit) r_state <= S_FAULT;
                end
                S_WB: begin
                    r_state <= w_after_retire;
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_seq.sv
// tb/tb_multicycle_seq.sv - scoreboard bench for the multi-cycle sequencer
module tb_multicycle_seq;
    import seq_pkg::*;

    localparam int TW = 3;
    localparam int CW = 32;

    logic          clock, reset;
    logic          io_start, io_halt;
    logic          io_dec_mem_read, io_dec_mem_write, io_dec_reg_write, io_dec_branch;
    logic          io_alu_zero;
    logic          io_imem_req, io_imem_ack;
    logic          io_dmem_req, io_dmem_we, io_dmem_ack;
    logic          io_ir_write, io_pc_write, io_pc_sel, io_rf_write;
    logic          io_busy, io_fault;
    logic [CW-1:0] io_retired;

    typedef struct {
        logic        sel;
        logic        rf;
        int          lat;
        logic        mem;
        logic        we;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] exp_ret  = 0;
    int          imem_delay = 0, dmem_delay = 0;
    logic        imem_en = 1'b1;
    int          ni = 0, nd = 0;

    multicycle_seq #(.TIMEOUT_W(TW), .CNT_W(CW)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_start         (io_start),
        .io_halt          (io_halt),
        .io_dec_mem_read  (io_dec_mem_read),
        .io_dec_mem_write (io_dec_mem_write),
        .io_dec_reg_write (io_dec_reg_write),
        .io_dec_branch    (io_dec_branch),
        .io_alu_zero      (io_alu_zero),
        .io_imem_req      (io_imem_req),
        .io_imem_ack      (io_imem_ack),
        .io_dmem_req      (io_dmem_req),
        .io_dmem_we       (io_dmem_we),
        .io_dmem_ack      (io_dmem_ack),
        .io_ir_write      (io_ir_write),
        .io_pc_write      (io_pc_write),
        .io_pc_sel        (io_pc_sel),
        .io_rf_write      (io_rf_write),
        .io_busy          (io_busy),
        .io_fault         (io_fault),
        .io_retired       (io_retired)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responders: ack after a programmable number of wait cycles
    initial begin
        io_imem_ack = 1'b0;
        io_dmem_ack = 1'b0;
        forever begin
            @(posedge clock);
            #3;
            if (io_imem_req && imem_en) begin
                if (ni == imem_delay) begin io_imem_ack = 1'b1; ni = 0; end
                else begin io_imem_ack = 1'b0; ni++; end
            end else begin
                io_imem_ack = 1'b0; ni = 0;
            end
            if (io_dmem_req) begin
                if (nd == dmem_delay) begin io_dmem_ack = 1'b1; nd = 0; end
                else begin io_dmem_ack = 1'b0; nd++; end
            end else begin
                io_dmem_ack = 1'b0; nd = 0;
            end
        end
    end

    // Monitor: pops an expectation at every retire and checks data-access direction
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset || !io_busy) begin
                cyc = 0;
            end else begin
                cyc++;
                if (io_dmem_req && io_dmem_ack) begin
                    if (sb.size() == 0) check("unexpected_dmem_ack", 64'(1), 64'(0));
                    else check("dmem_we", 64'(io_dmem_we), 64'(sb[0].we));
                end
                if (io_pc_write) begin
                    if (sb.size() == 0) begin
                        check("unexpected_retire", 64'(1), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check("retire_latency", 64'(cyc), 64'(e.lat));
                        check("retire_pc_sel", 64'(io_pc_sel), 64'(e.sel));
                        check("retire_rf_write", 64'(io_rf_write), 64'(e.rf));
                        check("retire_count_before", 64'(io_retired), 64'(e.ret));
                    end
                    cyc = 0;
                end
            end
        end
    end

    task automatic run(input logic rd, input logic wr, input logic rw, input logic br,
                       input logic z, input int idly, input int ddly, input logic halt,
                       input int lat, input logic sel, input logic rf);
        exp_t e;
        logic done;
        @(posedge clock); #2;
        io_dec_mem_read  = rd;
        io_dec_mem_write = wr;
        io_dec_reg_write = rw;
        io_dec_branch    = br;
        io_alu_zero      = z;
        imem_delay       = idly;
        dmem_delay       = ddly;
        io_halt          = halt;
        if (!io_busy) io_start = 1'b1;
        e = '{sel, rf, lat, rd | wr, wr, exp_ret};
        sb.push_back(e);
        exp_ret++;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (io_busy) io_start = 1'b0;
            if (io_pc_write) done = 1'b1;
        end
        if (!done) check("retire_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_fault", 64'(io_fault), 64'(0));
        check("reset_retired", 64'(io_retired), 64'(0));
        check("reset_reqs", 64'({io_imem_req, io_dmem_req, io_busy}), 64'(0));
        sb.delete();
        exp_ret = 0;
        @(posedge clock); #2;
        reset = 1'b1;
    endtask

    initial begin
        state_t st[4];
        logic   seen;
        int     waits;
        st = '{S_FETCH, S_DECODE, S_EXEC, S_WB};
        reset = 1'b0; io_start = 1'b0; io_halt = 1'b0;
        io_dec_mem_read = 1'b0; io_dec_mem_write = 1'b0;
        io_dec_reg_write = 1'b0; io_dec_branch = 1'b0; io_alu_zero = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_outputs", 64'({io_imem_req, io_dmem_req, io_dmem_we, io_ir_write,
                                  io_pc_write, io_pc_sel, io_rf_write}), 64'(0));
        check("rst_busy_fault", 64'({io_busy, io_fault}), 64'(0));
        check("rst_retired", 64'(io_retired), 64'(0));
        @(posedge clock); #2;
        reset = 1'b1;

        // ALU op with state trace
        @(posedge clock); #2;
        io_dec_reg_write = 1'b1; io_halt = 1'b1; io_start = 1'b1;
        sb.push_back('{1'b0, 1'b1, 4, 1'b0, 1'b0, exp_ret});
        exp_ret++;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            io_start = 1'b0;
            check("alu_state", 64'(dut.r_state), 64'(st[i]));
            check("alu_rf_pc_write", 64'({io_rf_write, io_pc_write}), (i == 3) ? 64'(3) : 64'(0));
        end
        @(negedge clock);
        check("alu_retired", 64'(io_retired), 64'(1));
        check("alu_idle", 64'(io_busy), 64'(0));

        // load with three dmem wait cycles
        run(1, 0, 1, 0, 0, 0, 3, 1, 8, 0, 1);
        // back-to-back: branch taken, branch not taken, no-write with ack in limit cycle, store with halt
        run(0, 0, 0, 1, 1, 0, 0, 0, 3, 1, 0);
        run(0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0);
        run(0, 0, 0, 0, 0, 6, 0, 0, 9, 0, 0);
        run(0, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        @(negedge clock);
        check("halt_busy", 64'(io_busy), 64'(0));
        check("halt_retired", 64'(io_retired), 64'(6));
        repeat (2) @(negedge clock);
        check("halt_stays_idle", 64'({io_busy, io_imem_req}), 64'(0));

        // illegal hint combination
        @(posedge clock); #2;
        io_dec_mem_read = 1'b1; io_dec_mem_write = 1'b1; io_dec_reg_write = 1'b0;
        io_dec_branch = 1'b0; io_halt = 1'b0; imem_delay = 0; io_start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (io_busy) begin seen = 1'b1; io_start = 1'b0; end
        end
        check("illegal_started", 64'(seen), 64'(1));
        repeat (2) @(negedge clock);
        check("illegal_exec_no_fault", 64'({io_fault, io_pc_write}), 64'(0));
        @(negedge clock);
        check("illegal_fault", 64'(io_fault), 64'(1));
        check("illegal_busy", 64'(io_busy), 64'(0));
        check("illegal_retired", 64'(io_retired), 64'(6));
        repeat (3) @(negedge clock);
        check("illegal_sticky", 64'({io_fault, io_imem_req, io_dmem_req, io_pc_write}), 64'(8));
        do_reset();

        // one ALU op, then reset mid-MEM of a load whose ack never arrives in time
        io_dec_mem_read = 1'b0; io_dec_mem_write = 1'b0;
        run(0, 0, 1, 0, 0, 0, 0, 1, 4, 0, 1);
        @(posedge clock); #2;
        io_dec_mem_read = 1'b1; io_dec_reg_write = 1'b1; dmem_delay = 100; io_start = 1'b1;
        sb.push_back('{1'b0, 1'b1, 0, 1'b1, 1'b0, exp_ret});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (io_busy) io_start = 1'b0;
            if (io_dmem_req) seen = 1'b1;
        end
        check("mem_reached", 64'(seen), 64'(1));
        check("mem_retired_before", 64'(io_retired), 64'(1));
        do_reset();
        check("mem_reset_req", 64'(io_dmem_req), 64'(0));

        // fetch timeout with no imem ack
        imem_en = 1'b0;
        io_dec_mem_read = 1'b0; io_dec_reg_write = 1'b0;
        @(posedge clock); #2;
        io_start = 1'b1;
        waits = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            if (io_busy) io_start = 1'b0;
            if (io_fault) seen = 1'b1;
            else if (io_imem_req) waits++;
        end
        check("timeout_wait_cycles", 64'(waits), 64'(7));
        check("timeout_fault", 64'(io_fault), 64'(1));
        repeat (3) @(negedge clock);
        check("timeout_sticky", 64'({io_fault, io_imem_req, io_dmem_req, io_ir_write}), 64'(8));
        imem_en = 1'b1;
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
